// File: rtl/f_fetch_unit.sv
// Fetch stage of the 5-stage MIPS pipeline: PC register, imem request/ready handshake,
// delayed-branch redirects and flushes. Define F_ADDR_RANGE_CHECK_EN to fault fetches outside [IMEM_BASE, IMEM_TOP].
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [31:0] IMEM_TOP  = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_pc,
    output logic [31:0] F_instr,
    output logic        F_valid,
    output logic [4:0]  F_exccode
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HAVE = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic bad_c;
    logic handoff_c;

`ifdef F_ADDR_RANGE_CHECK_EN
    assign bad_c = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) || (pc_q > IMEM_TOP);
`else
    assign bad_c = (pc_q[1:0] != 2'b00);
`endif

    // Presented instruction: bypass from imem in REQ, buffered word in HAVE.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        F_pc      = pc_q;
        F_instr   = 32'd0;
        F_valid   = 1'b0;
        F_exccode = 5'd0;
        if (reset) begin
            F_pc = RESET_PC;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (bad_c) begin
                        F_valid   = 1'b1;
                        F_exccode = EXC_ADEL;
                    end else begin
                        imem_req = 1'b1;
                        F_valid  = imem_ready;
                        F_instr  = imem_ready ? imem_rdata : 32'd0;
                    end
                end
                S_HAVE: begin
                    F_valid = 1'b1;
                    F_instr = ibuf_q;
                end
                default: ;
            endcase
        end
    end

    assign handoff_c = F_valid & en & ~flush;

    // Next-state: flush > handoff > (pending redirect capture, stall buffering).
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ibuf_d     = ibuf_q;
        pend_v_d   = pend_v_q;
        pend_tgt_d = pend_tgt_q;
        if (flush) begin
            pc_d     = flush_target;
            state_d  = S_REQ;
            pend_v_d = 1'b0;
            ibuf_d   = 32'd0;
        end else if (handoff_c) begin
            if (redirect_valid)
                pc_d = redirect_target;
            else if (pend_v_q)
                pc_d = pend_tgt_q;
            else
                pc_d = pc_q + 32'd4;
            state_d  = S_REQ;
            pend_v_d = 1'b0;
        end else begin
            if (redirect_valid) begin
                pend_v_d   = 1'b1;
                pend_tgt_d = redirect_target;
            end
            if (state_q == S_REQ && imem_ready && !bad_c && !en) begin
                ibuf_d  = imem_rdata;
                state_d = S_HAVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            ibuf_q     <= 32'd0;
            pend_v_q   <= 1'b0;
            pend_tgt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ibuf_q     <= ibuf_d;
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule

// File: doc/f_fetch_unit.md
Name: f_fetch_unit

Overview:
- Fetch-stage unit of the 5-stage MIPS pipeline. Sits directly upstream of the F/D pipeline register.
- Owns the PC register and runs the instruction-memory request/ready handshake.
- Applies branch/jump redirects from D with one delay slot, and exception/eret flushes.
- Presents F_pc, F_instr, F_valid and F_exccode for the F/D register to capture when the hazard unit asserts en.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
IMEM_BASE, 32'h0000_3000, lowest legal fetch address
IMEM_TOP, 32'h0000_6FFC, highest legal fetch address (inclusive)
EXC_ADEL, 5'd4, exception code for an illegal fetch address

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
en  input  1  stage advance from hazard unit; same signal drives the F/D register enable
redirect_valid  input  1  D-stage control transfer resolved; the instruction after the current F instruction comes from redirect_target
redirect_target  input  32  branch/jump/jr target
flush  input  1  exception entry or eret; overrides everything
flush_target  input  32  handler address (0x4180) or EPC
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (= pc)
imem_ready  input  1  read data valid this cycle; may assert in the same cycle as imem_req
imem_rdata  input  32  instruction word
F_pc  output  32  PC of the presented instruction
F_instr  output  32  presented instruction; 0 (nop) when not valid or on exception
F_valid  output  1  F_instr/F_pc/F_exccode are meaningful this cycle
F_exccode  output  5  0 = none, EXC_ADEL = bad fetch address

Behaviour:
- State: pc (32), state in {REQ, HAVE}, ibuf (32), pend_v, pend_tgt (32).
- Reset values: pc=RESET_PC, state=REQ, ibuf=0, pend_v=0, pend_tgt=0.
  - Outputs during the reset cycle: imem_req=0, F_valid=0, F_instr=0, F_exccode=0, F_pc=RESET_PC.
- bad = (pc[1:0]!=0). The optional feature adds a range check to this condition.
- REQ, bad=0:
  - imem_req=1, imem_addr=pc.
  - F_valid=imem_ready; F_instr = imem_ready ? imem_rdata : 0 (combinational bypass).
- REQ, bad=1:
  - imem_req=0; F_valid=1, F_instr=0, F_exccode=EXC_ADEL.
- HAVE:
  - imem_req=0; F_valid=1, F_instr=ibuf, F_exccode=0.
- F_pc=pc in all states.
- handoff = F_valid & en & ~flush.
- Next pc on handoff, in priority order:
  - redirect_valid → redirect_target
  - else pend_v → pend_tgt
  - else pc+4 (mod 2^32, wraps)
  - Then state→REQ, pend_v→0.
- Zero-wait memory with en=1: one instruction per cycle, no bubbles.
- REQ & imem_ready & ~en & ~bad & ~flush: ibuf←imem_rdata, state→HAVE, pc unchanged. The request is not reissued.
- REQ & ~imem_ready: hold the request; the address stays stable.
- redirect_valid without handoff: pend_v←1, pend_tgt←redirect_target. The current or pending fetch is the delay slot and is still delivered. A second redirect overwrites the first (newest wins).
- flush (highest priority, any state):
  - pc←flush_target, state→REQ, pend_v←0, ibuf←0.
  - Outputs in the flush cycle are don't-care. The F/D register is refreshed in the same cycle.
  - A request abandoned by flush is dropped; imem must tolerate imem_req deasserting before imem_ready.
- Reset mid-fetch: same as flush, but to RESET_PC.
- redirect_valid & flush in the same cycle: flush wins; the redirect is discarded.

Optional Feature:
- Macro: F_ADDR_RANGE_CHECK_EN.
- Defined: bad also asserts when pc<IMEM_BASE or pc>IMEM_TOP, giving the same EXC_ADEL response with no request.
- Undefined: only the alignment check applies. Out-of-range aligned addresses are requested normally.

Test Plan:
- Reset, imem_ready tied 1, en=1 → imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; F_instr equals imem_rdata each cycle.
- imem_ready low 3 cycles at pc 0x3008 → imem_req held, imem_addr=0x3008, F_valid=0. On the 4th cycle F_valid=1, then pc→0x300C.
- Stall: en=0 while ready=1 at 0x3004 → state HAVE, no new request, F_instr stable for 2 cycles. After en=1, next address 0x3008.
- Branch at 0x3000 in D asserts redirect_valid to 0x3100 while F holds 0x3004 → 0x3004 is delivered (delay slot), next fetch 0x3100. Repeat with the slot fetch stalled on ready → pending target used, still 0x3100.
- flush to 0x4180 concurrent with redirect_valid to 0x3100 → next imem_addr 0x4180; pend_v cleared; no 0x3100 fetch follows.
- redirect to 0x3102 → next cycle F_valid=1, F_instr=0, F_exccode=4, imem_req=0. With F_ADDR_RANGE_CHECK_EN, redirect to 0x8000 → same response.
